// File: rtl/camera_follow_if.sv
// camera_follow_if: frame request, tracked target and camera result signals of camera_follow.
interface camera_follow_if #(
    parameter int WORLD_BITS = 32
) ();
    logic                         new_frame_in;
    logic                         target_valid_in;
    logic                         snap_in;
    logic signed [WORLD_BITS-1:0] target_x_in;
    logic signed [WORLD_BITS-1:0] target_y_in;
    logic signed [WORLD_BITS-1:0] camera_x_out;
    logic signed [WORLD_BITS-1:0] camera_y_out;
    logic                         camera_valid_out;
    logic                         busy_out;
    logic                         missed_out;
    modport master (
        output new_frame_in, target_valid_in, snap_in, target_x_in, target_y_in,
        input  camera_x_out, camera_y_out, camera_valid_out, busy_out, missed_out
    );
    modport slave (
        input  new_frame_in, target_valid_in, snap_in, target_x_in, target_y_in,
        output camera_x_out, camera_y_out, camera_valid_out, busy_out, missed_out
    );
endinterface

// File: rtl/camera_follow.sv
// camera_follow: once per frame eases the camera toward the tracked target with a deadzone, optional snap and bound clamp.
module camera_follow #(
    parameter int                           WORLD_BITS   = 32,
    parameter int                           SMOOTH_SHIFT = 3,
    parameter int unsigned                  DEADZONE     = 64,
    parameter logic signed [WORLD_BITS-1:0] MIN_X        = -(2**20),
    parameter logic signed [WORLD_BITS-1:0] MAX_X        = 2**20,
    parameter logic signed [WORLD_BITS-1:0] MIN_Y        = -(2**20),
    parameter logic signed [WORLD_BITS-1:0] MAX_Y        = 2**20,
    parameter logic signed [WORLD_BITS-1:0] RESET_X      = '0,
    parameter logic signed [WORLD_BITS-1:0] RESET_Y      = '0
) (
    input logic            clk_in,
    input logic            rst_n_in,
    camera_follow_if.slave bus_io
);
    typedef enum logic [2:0] {IDLE, CAPTURE, STEP, CLAMP, COMMIT} state_t;
    localparam logic signed [WORLD_BITS:0] DZ  = (WORLD_BITS+1)'(DEADZONE);
    localparam logic signed [WORLD_BITS:0] ONE = (WORLD_BITS+1)'(1);
    state_t                       state_q, state_d;
    logic signed [WORLD_BITS-1:0] tgt_x_q, tgt_y_q, sx_q, sy_q, cx_q, cy_q, cam_x_q, cam_y_q;
    logic signed [WORLD_BITS:0]   nx_q, ny_q;
    logic                         snap_q, valid_q, missed_q;
    function automatic logic signed [WORLD_BITS:0] ext(input logic signed [WORLD_BITS-1:0] v);
        return {v[WORLD_BITS-1], v};
    endfunction
    // Step outside the deadzone is never zero so the camera always closes in.
    function automatic logic signed [WORLD_BITS:0] ease(input logic signed [WORLD_BITS:0] e);
        logic signed [WORLD_BITS:0] p, n;
        p = (e - DZ) >>> SMOOTH_SHIFT;
        n = (e + DZ) >>> SMOOTH_SHIFT;
        return (e > DZ) ? ((p == '0) ? ONE : p) : (e < -DZ) ? ((n == '0) ? -ONE : n) : '0;
    endfunction
    function automatic logic signed [WORLD_BITS-1:0] clamp(input logic signed [WORLD_BITS:0] v,
                                                           input logic signed [WORLD_BITS-1:0] lo,
                                                           input logic signed [WORLD_BITS-1:0] hi);
        return (v < ext(lo)) ? lo : (v > ext(hi)) ? hi : v[WORLD_BITS-1:0];
    endfunction
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus_io.new_frame_in ? CAPTURE : IDLE;
            CAPTURE: state_d = STEP;
            STEP:    state_d = CLAMP;
            CLAMP:   state_d = COMMIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            tgt_x_q  <= RESET_X;
            tgt_y_q  <= RESET_Y;
            cam_x_q  <= RESET_X;
            cam_y_q  <= RESET_Y;
            snap_q   <= 1'b0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= state_q == COMMIT;
            if (bus_io.target_valid_in) begin
                tgt_x_q <= bus_io.target_x_in;
                tgt_y_q <= bus_io.target_y_in;
            end
            // snap_in belongs to the frame pulse, so it is taken on that same edge.
            if (state_q == IDLE && bus_io.new_frame_in) snap_q <= bus_io.snap_in;
            if (state_q != IDLE && bus_io.new_frame_in) missed_q <= 1'b1;
            if (state_q == CAPTURE) begin
                sx_q <= tgt_x_q;
                sy_q <= tgt_y_q;
            end
            if (state_q == STEP) begin
                nx_q <= snap_q ? ext(sx_q) : ext(cam_x_q) + ease(ext(sx_q) - ext(cam_x_q));
                ny_q <= snap_q ? ext(sy_q) : ext(cam_y_q) + ease(ext(sy_q) - ext(cam_y_q));
            end
            if (state_q == CLAMP) begin
                cx_q <= clamp(nx_q, MIN_X, MAX_X);
                cy_q <= clamp(ny_q, MIN_Y, MAX_Y);
            end
            if (state_q == COMMIT) begin
                cam_x_q <= cx_q;
                cam_y_q <= cy_q;
            end
        end
    end
    assign bus_io.camera_x_out     = cam_x_q;
    assign bus_io.camera_y_out     = cam_y_q;
    assign bus_io.camera_valid_out = valid_q;
    assign bus_io.busy_out         = state_q != IDLE;
    assign bus_io.missed_out       = missed_q;
endmodule

// File: tb/tb_camera_follow.sv
// tb_camera_follow: directed frame updates against hand-computed camera positions.
module tb_camera_follow;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    camera_follow_if #(.WORLD_BITS(32)) bus ();
    camera_follow dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus_io(bus));
    always #5 clk_in = ~clk_in;
    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask
    task automatic drive(input logic nf, input logic s, input logic tv, input longint tx, input longint ty);
        bus.new_frame_in    = nf;
        bus.snap_in         = s;
        bus.target_valid_in = tv;
        bus.target_x_in     = 32'(tx);
        bus.target_y_in     = 32'(ty);
    endtask
    task automatic do_frame(input string tag, input logic s, input logic tv,
                            input longint tx, input longint ty, input longint ex, input longint ey);
        int lat = -1;
        int pulses = 0;
        drive(1'b1, s, tv, tx, ty);
        tick;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (bus.camera_valid_out) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        chk({tag, ".lat"}, lat, 4);
        chk({tag, ".pulses"}, pulses, 1);
        chk({tag, ".x"}, bus.camera_x_out, ex);
        chk({tag, ".y"}, bus.camera_y_out, ey);
    endtask
    initial begin
        int pulses;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        tick;
        tick;
        chk("rst.x", bus.camera_x_out, 0);
        chk("rst.y", bus.camera_y_out, 0);
        chk("rst.valid", bus.camera_valid_out, 0);
        chk("rst.busy", bus.busy_out, 0);
        chk("rst.missed", bus.missed_out, 0);
        rst_n_in = 1'b1;
        do_frame("deadzone", 1'b0, 1'b1, 50, -64, 0, 0);
        do_frame("ease1", 1'b0, 1'b1, 1000, -1000, 117, -117);
        do_frame("ease2", 1'b0, 1'b1, 1000, -117, 219, -117);
        do_frame("snap0", 1'b1, 1'b1, 0, 0, 0, 0);
        do_frame("minstep", 1'b0, 1'b1, 70, 0, 1, 0);
        do_frame("snapclamp", 1'b1, 1'b1, 2097152, -5, 1048576, -5);
        do_frame("snapy", 1'b1, 1'b1, 0, -1048576, 0, -1048576);
        do_frame("clampy", 1'b0, 1'b1, 0, -2097152, 0, -1048576);
        drive(1'b1, 1'b0, 1'b1, 1000, 0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        tick;
        bus.new_frame_in = 1'b1;
        tick;
        bus.new_frame_in = 1'b0;
        chk("overlap.busy", bus.busy_out, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bus.camera_valid_out) pulses++;
        end
        chk("overlap.pulses", pulses, 1);
        chk("overlap.missed", bus.missed_out, 1);
        chk("overlap.x", bus.camera_x_out, 117);
        chk("overlap.y", bus.camera_y_out, -917512);
        do_frame("latest", 1'b0, 1'b0, 0, 0, 219, -802831);
        chk("sticky.missed", bus.missed_out, 1);
        drive(1'b1, 1'b0, 1'b1, 5000, 5000);
        tick;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        tick;
        rst_n_in = 1'b0;
        tick;
        chk("abort.x", bus.camera_x_out, 0);
        chk("abort.y", bus.camera_y_out, 0);
        chk("abort.valid", bus.camera_valid_out, 0);
        chk("abort.busy", bus.busy_out, 0);
        chk("abort.missed", bus.missed_out, 0);
        rst_n_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus.camera_valid_out) pulses++;
        end
        chk("abort.pulses", pulses, 0);
        do_frame("rsttarget", 1'b0, 1'b0, 0, 0, 0, 0);
        rst_n_in = 1'b0;
        tick;
        rst_n_in = 1'b1;
        do_frame("firstframe", 1'b0, 1'b1, 1000, 1000, 117, 117);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
